operand_fetch_stage: RTL and testbench

- Decode-side operand stage wrapped around the synchronous-read register file.
- Drives the RF read addresses and captures the registered RF_RS1/RF_RS2 one cycle later.
- Corrects the operands for same-edge writeback and in-flight results, and detects load-use hazards.
- Presents valid operands to the execute stage over a valid/ready handshake.

---
 rtl/operand_fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-side operand stage wrapped around a synchronous-read register
//   file. Drives the RF read addresses, captures the registered read data a
//   cycle later, corrects it for same-edge writeback and in-flight results,
//   detects load-use hazards and offers operands to execute over valid/ready.
//
//   Build option: OPS_FWD_EN
//     defined   - MEM-stage ALU results are forwarded; only loads in EX/MEM
//                 cause a hazard.
//     undefined - no MEM forwarding; any EX/MEM destination match hazards.
//
// Ports
//   CLK, RST_N                     clock, async active-low reset
//   DEC_VALID/DEC_ADR1/DEC_ADR2    decode offer of source addresses
//   DEC_READY                      stage accepts the offer this cycle
//   RF_ADR1/RF_ADR2                RF read addresses
//   RF_RS1/RF_RS2                  RF registered read data
//   WB_EN/WB_WA/WB_WD              writeback (also the RF write port)
//   MEM_EN/MEM_WA/MEM_WD/MEM_IS_LOAD  MEM-stage destination info
//   EX_EN/EX_WA/EX_IS_LOAD         EX-stage destination info
//   FLUSH                          discard held and incoming instruction
//   EX_READY                       execute accepts operands
//   OP_VALID/OP_ADR1/OP_ADR2/OP_RS1/OP_RS2  operand bundle to execute
module operand_fetch_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              DEC_VALID,
    input  logic [REG_AW-1:0] DEC_ADR1,
    input  logic [REG_AW-1:0] DEC_ADR2,
    output logic              DEC_READY,
    output logic [REG_AW-1:0] RF_ADR1,
    output logic [REG_AW-1:0] RF_ADR2,
    input  logic [XLEN-1:0]   RF_RS1,
    input  logic [XLEN-1:0]   RF_RS2,
    input  logic              WB_EN,
    input  logic [REG_AW-1:0] WB_WA,
    input  logic [XLEN-1:0]   WB_WD,
    input  logic              MEM_EN,
    input  logic [REG_AW-1:0] MEM_WA,
    input  logic [XLEN-1:0]   MEM_WD,
    input  logic              MEM_IS_LOAD,
    input  logic              EX_EN,
    input  logic [REG_AW-1:0] EX_WA,
    input  logic              EX_IS_LOAD,
    input  logic              FLUSH,
    input  logic              EX_READY,
    output logic              OP_VALID,
    output logic [REG_AW-1:0] OP_ADR1,
    output logic [REG_AW-1:0] OP_ADR2,
    output logic [XLEN-1:0]   OP_RS1,
    output logic [XLEN-1:0]   OP_RS2
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_STALL
    } state_t;

    state_t            state_q, state_d;
    logic [REG_AW-1:0] adr1_q, adr1_d, adr2_q, adr2_d;
    logic              byp1_q, byp1_d, byp2_q, byp2_d;
    logic [XLEN-1:0]   bypd1_q, bypd1_d, bypd2_q, bypd2_d;

    logic ex_haz_en, mem_haz_en, mem_fwd_en;
    logic haz1, haz2, hazard;
    logic op_valid, dec_ready;

`ifdef OPS_FWD_EN
    assign ex_haz_en  = EX_EN & EX_IS_LOAD;
    assign mem_haz_en = MEM_EN & MEM_IS_LOAD;
    assign mem_fwd_en = MEM_EN & ~MEM_IS_LOAD;
`else
    logic unused_nofwd;
    assign unused_nofwd = EX_IS_LOAD ^ MEM_IS_LOAD;
    assign ex_haz_en    = EX_EN;
    assign mem_haz_en   = MEM_EN;
    assign mem_fwd_en   = 1'b0;
`endif

    // Newest architectural value of one source, in forwarding priority order.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_AW-1:0] adr,
        input logic              fwd_en,
        input logic [REG_AW-1:0] mem_wa,
        input logic [XLEN-1:0]   mem_wd,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_wa,
        input logic [XLEN-1:0]   wb_wd,
        input logic              byp,
        input logic [XLEN-1:0]   byp_data,
        input logic [XLEN-1:0]   rf_data
    );
        if (adr == '0)                    return '0;
        else if (fwd_en && mem_wa == adr) return mem_wd;
        else if (wb_en && wb_wa == adr)   return wb_wd;
        else if (byp)                     return byp_data;
        else                              return rf_data;
    endfunction

    assign haz1 = (adr1_q != '0) &
                  ((ex_haz_en & (EX_WA == adr1_q)) | (mem_haz_en & (MEM_WA == adr1_q)));
    assign haz2 = (adr2_q != '0) &
                  ((ex_haz_en & (EX_WA == adr2_q)) | (mem_haz_en & (MEM_WA == adr2_q)));
    assign hazard = haz1 | haz2;

    assign op_valid  = (state_q != S_EMPTY) & ~hazard;
    assign dec_ready = (state_q == S_EMPTY) | (op_valid & EX_READY);

    // While holding, re-read the held addresses so RF data tracks new writes.
    assign RF_ADR1 = dec_ready ? DEC_ADR1 : adr1_q;
    assign RF_ADR2 = dec_ready ? DEC_ADR2 : adr2_q;

    always_comb begin
        state_d = state_q;
        adr1_d  = adr1_q;
        adr2_d  = adr2_q;
        if (FLUSH) begin
            state_d = S_EMPTY;
        end else if (DEC_VALID && dec_ready) begin
            state_d = S_FULL;
            adr1_d  = DEC_ADR1;
            adr2_d  = DEC_ADR2;
        end else if (op_valid && EX_READY) begin
            state_d = S_EMPTY;
        end else if (state_q != S_EMPTY) begin
            state_d = hazard ? S_STALL : S_FULL;
        end
    end

    // The RF returns the pre-write value when read and written on the same
    // edge, so remember the written data for the following cycle.
    always_comb begin
        byp1_d  = WB_EN & (WB_WA == RF_ADR1) & (RF_ADR1 != '0);
        byp2_d  = WB_EN & (WB_WA == RF_ADR2) & (RF_ADR2 != '0);
        bypd1_d = byp1_d ? WB_WD : bypd1_q;
        bypd2_d = byp2_d ? WB_WD : bypd2_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_EMPTY;
            adr1_q  <= '0;
            adr2_q  <= '0;
            byp1_q  <= 1'b0;
            byp2_q  <= 1'b0;
            bypd1_q <= '0;
            bypd2_q <= '0;
        end else begin
            state_q <= state_d;
            adr1_q  <= adr1_d;
            adr2_q  <= adr2_d;
            byp1_q  <= byp1_d;
            byp2_q  <= byp2_d;
            bypd1_q <= bypd1_d;
            bypd2_q <= bypd2_d;
        end
    end

    assign DEC_READY = dec_ready;
    assign OP_VALID  = op_valid;
    assign OP_ADR1   = adr1_q;
    assign OP_ADR2   = adr2_q;
    assign OP_RS1    = resolve(adr1_q, mem_fwd_en, MEM_WA, MEM_WD, WB_EN, WB_WA, WB_WD,
                               byp1_q, bypd1_q, RF_RS1);
    assign OP_RS2    = resolve(adr2_q, mem_fwd_en, MEM_WA, MEM_WD, WB_EN, WB_WA, WB_WD,
                               byp2_q, bypd2_q, RF_RS2);

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage
//   Self-checking bench for operand_fetch_stage. Contains a synchronous-read
//   register file driven by the writeback port, directed scenarios and a
//   randomized run checked against an architectural "newest value" model.
module tb_operand_fetch_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            DEC_VALID;
    logic [AW-1:0]   DEC_ADR1, DEC_ADR2;
    logic            DEC_READY;
    logic [AW-1:0]   RF_ADR1, RF_ADR2;
    logic [XLEN-1:0] RF_RS1, RF_RS2;
    logic            WB_EN;
    logic [AW-1:0]   WB_WA;
    logic [XLEN-1:0] WB_WD;
    logic            MEM_EN;
    logic [AW-1:0]   MEM_WA;
    logic [XLEN-1:0] MEM_WD;
    logic            MEM_IS_LOAD;
    logic            EX_EN;
    logic [AW-1:0]   EX_WA;
    logic            EX_IS_LOAD;
    logic            FLUSH;
    logic            EX_READY;
    logic            OP_VALID;
    logic [AW-1:0]   OP_ADR1, OP_ADR2;
    logic [XLEN-1:0] OP_RS1, OP_RS2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] rf [32];

    // Reference model state: is an instruction held, and its sources.
    bit            m_held;
    logic [AW-1:0] m_a1, m_a2;

    operand_fetch_stage #(.XLEN(XLEN), .REG_AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .DEC_VALID(DEC_VALID), .DEC_ADR1(DEC_ADR1), .DEC_ADR2(DEC_ADR2), .DEC_READY(DEC_READY),
        .RF_ADR1(RF_ADR1), .RF_ADR2(RF_ADR2), .RF_RS1(RF_RS1), .RF_RS2(RF_RS2),
        .WB_EN(WB_EN), .WB_WA(WB_WA), .WB_WD(WB_WD),
        .MEM_EN(MEM_EN), .MEM_WA(MEM_WA), .MEM_WD(MEM_WD), .MEM_IS_LOAD(MEM_IS_LOAD),
        .EX_EN(EX_EN), .EX_WA(EX_WA), .EX_IS_LOAD(EX_IS_LOAD),
        .FLUSH(FLUSH), .EX_READY(EX_READY),
        .OP_VALID(OP_VALID), .OP_ADR1(OP_ADR1), .OP_ADR2(OP_ADR2),
        .OP_RS1(OP_RS1), .OP_RS2(OP_RS2)
    );

    always #5 CLK = ~CLK;

    // Register file: registered read of the pre-write contents, x0 reads zero.
    always @(posedge CLK) begin
        RF_RS1 <= (RF_ADR1 == '0) ? '0 : rf[RF_ADR1];
        RF_RS2 <= (RF_ADR2 == '0) ? '0 : rf[RF_ADR2];
        if (WB_EN && WB_WA != '0) rf[WB_WA] <= WB_WD;
    end

    // Does an in-flight producer make source a unavailable this cycle?
    function automatic bit m_haz(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef OPS_FWD_EN
        return (EX_EN && EX_IS_LOAD && EX_WA == a) || (MEM_EN && MEM_IS_LOAD && MEM_WA == a);
`else
        return (EX_EN && EX_WA == a) || (MEM_EN && MEM_WA == a);
`endif
    endfunction

    // Value register a holds once every older in-flight write has landed.
    function automatic logic [XLEN-1:0] m_newest(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef OPS_FWD_EN
        if (MEM_EN && !MEM_IS_LOAD && MEM_WA == a) return MEM_WD;
`endif
        if (WB_EN && WB_WA == a) return WB_WD;
        return rf[a];
    endfunction

    task automatic idle_inputs();
        DEC_VALID = 1'b0; DEC_ADR1 = '0; DEC_ADR2 = '0;
        WB_EN = 1'b0; WB_WA = '0; WB_WD = '0;
        MEM_EN = 1'b0; MEM_WA = '0; MEM_WD = '0; MEM_IS_LOAD = 1'b0;
        EX_EN = 1'b0; EX_WA = '0; EX_IS_LOAD = 1'b0;
        FLUSH = 1'b0; EX_READY = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain();
        idle_inputs();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        idle_inputs();
        WB_EN = 1'b1; WB_WA = a; WB_WD = d;
        tick();
        WB_EN = 1'b0;
    endtask

    task automatic accept(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        idle_inputs();
        DEC_VALID = 1'b1; DEC_ADR1 = a1; DEC_ADR2 = a2;
        tick();
        DEC_VALID = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 1'b0;
        @(negedge CLK); #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", OP_VALID); end
        n_tests++; if (OP_RS1 !== '0) begin n_fail++; $display("FAIL reset_rs1: got %h want 0", OP_RS1); end
        n_tests++; if (OP_RS2 !== '0) begin n_fail++; $display("FAIL reset_rs2: got %h want 0", OP_RS2); end
        n_tests++; if (OP_ADR1 !== '0) begin n_fail++; $display("FAIL reset_adr1: got %h want 0", OP_ADR1); end
        tick();
        RST_N = 1'b1;
        #1;
        n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", DEC_READY); end
        @(negedge CLK);
    endtask

    task automatic test_basic_read();
        wb_write(5'd5, 32'h1234);
        idle_inputs();
        DEC_VALID = 1'b1; DEC_ADR1 = 5'd5; DEC_ADR2 = 5'd0;
        #1;
        n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", DEC_READY); end
        tick();
        DEC_VALID = 1'b0; EX_READY = 1'b0;
        #1;
        n_tests++; if (OP_VALID !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", OP_VALID); end
        n_tests++; if (OP_RS1 !== 32'h1234) begin n_fail++; $display("FAIL basic_rs1: got %h want 1234", OP_RS1); end
        n_tests++; if (OP_RS2 !== 32'h0) begin n_fail++; $display("FAIL basic_rs2: got %h want 0", OP_RS2); end
        n_tests++; if (OP_ADR1 !== 5'd5) begin n_fail++; $display("FAIL basic_adr1: got %0d want 5", OP_ADR1); end
        drain();
    endtask

    task automatic test_same_edge_write();
        wb_write(5'd7, 32'h1111);
        idle_inputs();
        DEC_VALID = 1'b1; DEC_ADR1 = 5'd7;
        WB_EN = 1'b1; WB_WA = 5'd7; WB_WD = 32'hAAAA;
        tick();
        idle_inputs();
        EX_READY = 1'b0;
        #1;
        n_tests++; if (OP_VALID !== 1'b1) begin n_fail++; $display("FAIL sameedge_valid: got %b want 1", OP_VALID); end
        n_tests++; if (OP_RS1 !== 32'hAAAA) begin n_fail++; $display("FAIL sameedge_rs1: got %h want aaaa", OP_RS1); end
        tick();
        #1;
        n_tests++; if (OP_RS1 !== 32'hAAAA) begin n_fail++; $display("FAIL sameedge_rs1_hold: got %h want aaaa", OP_RS1); end
        drain();
    endtask

    task automatic test_forwarding();
        wb_write(5'd3, 32'h33);
        accept(5'd0, 5'd3);
        EX_READY = 1'b0;
        MEM_EN = 1'b1; MEM_WA = 5'd3; MEM_WD = 32'h55; MEM_IS_LOAD = 1'b0;
        #1;
`ifdef OPS_FWD_EN
        n_tests++; if (OP_VALID !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b want 1", OP_VALID); end
        n_tests++; if (OP_RS2 !== 32'h55) begin n_fail++; $display("FAIL fwd_rs2: got %h want 55", OP_RS2); end
`else
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL nofwd_valid: got %b want 0", OP_VALID); end
        n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL nofwd_ready: got %b want 0", DEC_READY); end
`endif
        tick();
        MEM_EN = 1'b0;
        #1;
        n_tests++; if (OP_VALID !== 1'b1) begin n_fail++; $display("FAIL fwd_clear_valid: got %b want 1", OP_VALID); end
        n_tests++; if (OP_RS2 !== 32'h33) begin n_fail++; $display("FAIL fwd_clear_rs2: got %h want 33", OP_RS2); end
        drain();
    endtask

    task automatic test_load_use();
        wb_write(5'd9, 32'h99);
        wb_write(5'd4, 32'h44);
        accept(5'd9, 5'd0);
        DEC_VALID = 1'b1; DEC_ADR1 = 5'd4;
        EX_EN = 1'b1; EX_WA = 5'd9; EX_IS_LOAD = 1'b1;
        #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL lu_ex_valid: got %b want 0", OP_VALID); end
        n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL lu_ex_ready: got %b want 0", DEC_READY); end
        tick();
        EX_EN = 1'b0;
        MEM_EN = 1'b1; MEM_WA = 5'd9; MEM_IS_LOAD = 1'b1; MEM_WD = 32'hDEAD;
        #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL lu_mem_valid: got %b want 0", OP_VALID); end
        n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL lu_mem_ready: got %b want 0", DEC_READY); end
        n_tests++; if (OP_ADR1 !== 5'd9) begin n_fail++; $display("FAIL lu_mem_adr1: got %0d want 9", OP_ADR1); end
        tick();
        MEM_EN = 1'b0; MEM_IS_LOAD = 1'b0;
        WB_EN = 1'b1; WB_WA = 5'd9; WB_WD = 32'hBEEF;
        #1;
        n_tests++; if (OP_VALID !== 1'b1) begin n_fail++; $display("FAIL lu_wb_valid: got %b want 1", OP_VALID); end
        n_tests++; if (OP_RS1 !== 32'hBEEF) begin n_fail++; $display("FAIL lu_wb_rs1: got %h want beef", OP_RS1); end
        n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL lu_wb_ready: got %b want 1", DEC_READY); end
        tick();
        idle_inputs();
        EX_READY = 1'b0;
        #1;
        n_tests++; if (OP_ADR1 !== 5'd4) begin n_fail++; $display("FAIL lu_next_adr1: got %0d want 4", OP_ADR1); end
        n_tests++; if (OP_RS1 !== 32'h44) begin n_fail++; $display("FAIL lu_next_rs1: got %h want 44", OP_RS1); end
        drain();
    endtask

    task automatic test_backpressure();
        wb_write(5'd12, 32'hC0DE);
        wb_write(5'd13, 32'hF00D);
        accept(5'd12, 5'd13);
        for (int i = 0; i < 3; i++) begin
            DEC_VALID = 1'b1; DEC_ADR1 = 5'd1; DEC_ADR2 = 5'd2; EX_READY = 1'b0;
            #1;
            n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, DEC_READY); end
            n_tests++; if (OP_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, OP_VALID); end
            n_tests++; if (OP_RS1 !== 32'hC0DE) begin n_fail++; $display("FAIL bp_rs1[%0d]: got %h want c0de", i, OP_RS1); end
            n_tests++; if (OP_RS2 !== 32'hF00D) begin n_fail++; $display("FAIL bp_rs2[%0d]: got %h want f00d", i, OP_RS2); end
            n_tests++; if (RF_ADR1 !== 5'd12) begin n_fail++; $display("FAIL bp_rfadr1[%0d]: got %0d want 12", i, RF_ADR1); end
            tick();
        end
        n_tests++; if (OP_ADR1 !== 5'd12) begin n_fail++; $display("FAIL bp_held_adr1: got %0d want 12", OP_ADR1); end
        EX_READY = 1'b1;
        #1;
        n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", DEC_READY); end
        tick();
        DEC_VALID = 1'b0; EX_READY = 1'b0;
        #1;
        n_tests++; if (OP_ADR1 !== 5'd1 || OP_ADR2 !== 5'd2) begin
            n_fail++; $display("FAIL bp_next_adr: got %0d/%0d want 1/2", OP_ADR1, OP_ADR2);
        end
        drain();
    endtask

    task automatic test_flush();
        wb_write(5'd6, 32'h66);
        accept(5'd6, 5'd0);
        EX_EN = 1'b1; EX_WA = 5'd6; EX_IS_LOAD = 1'b1; FLUSH = 1'b1;
        #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_stall_valid: got %b want 0", OP_VALID); end
        tick();
        idle_inputs();
        #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", OP_VALID); end
        n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", DEC_READY); end
        DEC_VALID = 1'b1; DEC_ADR1 = 5'd6; FLUSH = 1'b1;
        tick();
        DEC_VALID = 1'b0; FLUSH = 1'b0;
        #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_drop_valid: got %b want 0", OP_VALID); end
        drain();
    endtask

    task automatic test_reset_mid();
        accept(5'd6, 5'd0);
        EX_READY = 1'b0;
        #1;
        n_tests++; if (OP_VALID !== 1'b1 || OP_RS1 !== 32'h66) begin
            n_fail++; $display("FAIL rstmid_pre: got %b/%h want 1/66", OP_VALID, OP_RS1);
        end
        #2 RST_N = 1'b0;
        #1;
        n_tests++; if (OP_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", OP_VALID); end
        n_tests++; if (OP_RS1 !== '0) begin n_fail++; $display("FAIL rstmid_rs1: got %h want 0", OP_RS1); end
        n_tests++; if (OP_ADR1 !== '0) begin n_fail++; $display("FAIL rstmid_adr1: got %0d want 0", OP_ADR1); end
        @(negedge CLK);
        RST_N = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit            e_valid, e_ready, n_held;
        logic [AW-1:0] n_a1, n_a2, e_rf1;
        idle_inputs();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        m_held = 1'b0; m_a1 = '0; m_a2 = '0;
        for (int r = 1; r < 32; r++) wb_write(AW'(r), $urandom);
        for (int c = 0; c < 1500; c++) begin
            DEC_VALID   = ($urandom_range(0, 9) < 7);
            DEC_ADR1    = AW'($urandom_range(0, 3));
            DEC_ADR2    = AW'($urandom_range(0, 3));
            WB_EN       = ($urandom_range(0, 2) == 0);
            WB_WA       = AW'($urandom_range(0, 3));
            WB_WD       = $urandom;
            MEM_EN      = ($urandom_range(0, 2) == 0);
            MEM_WA      = AW'($urandom_range(0, 3));
            MEM_WD      = $urandom;
            MEM_IS_LOAD = ($urandom_range(0, 2) == 0);
            EX_EN       = ($urandom_range(0, 2) == 0);
            EX_WA       = AW'($urandom_range(0, 3));
            EX_IS_LOAD  = ($urandom_range(0, 2) == 0);
            FLUSH       = ($urandom_range(0, 19) == 0);
            EX_READY    = ($urandom_range(0, 3) != 0);
            #1;
            e_valid = m_held && !m_haz(m_a1) && !m_haz(m_a2);
            e_ready = !m_held || (e_valid && EX_READY);
            e_rf1   = e_ready ? DEC_ADR1 : m_a1;
            n_tests++; if (DEC_READY !== e_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, DEC_READY, e_ready); end
            n_tests++; if (OP_VALID !== e_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, OP_VALID, e_valid); end
            n_tests++; if (RF_ADR1 !== e_rf1) begin n_fail++; $display("FAIL rnd_rfadr1 c%0d: got %0d want %0d", c, RF_ADR1, e_rf1); end
            n_tests++; if (OP_ADR1 !== m_a1 || OP_ADR2 !== m_a2) begin
                n_fail++; $display("FAIL rnd_opadr c%0d: got %0d/%0d want %0d/%0d", c, OP_ADR1, OP_ADR2, m_a1, m_a2);
            end
            if (e_valid) begin
                n_tests++; if (OP_RS1 !== m_newest(m_a1)) begin
                    n_fail++; $display("FAIL rnd_rs1 c%0d: got %h want %h", c, OP_RS1, m_newest(m_a1));
                end
                n_tests++; if (OP_RS2 !== m_newest(m_a2)) begin
                    n_fail++; $display("FAIL rnd_rs2 c%0d: got %h want %h", c, OP_RS2, m_newest(m_a2));
                end
            end
            n_held = m_held; n_a1 = m_a1; n_a2 = m_a2;
            if (FLUSH) n_held = 1'b0;
            else if (DEC_VALID && e_ready) begin n_held = 1'b1; n_a1 = DEC_ADR1; n_a2 = DEC_ADR2; end
            else if (e_valid && EX_READY) n_held = 1'b0;
            tick();
            m_held = n_held; m_a1 = n_a1; m_a2 = n_a2;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_same_edge_write();
        test_forwarding();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
